// File: rtl/fmeas_pkg.sv
// Shared types, default timing constants and elaboration-time helpers
// for the frequency-measurement sequencer.
package fmeas_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_GATE,
        S_LATCH,
        S_SETTLE,
        S_OUTPUT
    } fmeas_state_e;

    localparam int DEF_NUM_OSC    = 4;
    localparam int DEF_LENGTH     = 20;
    localparam int DEF_GATE_W     = 16;
    localparam int DEF_RESET_HOLD = 4;
    localparam int DEF_LATCH_HOLD = 4;
    localparam int DEF_SETTLE     = 4;

    function automatic int fmeas_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int fmeas_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fmeas_next_sel.sv
// Round-robin search: next set mask bit strictly above idx_i, wrapping to the
// lowest set bit (wrap_o=1) when none lies above.
module fmeas_next_sel
    import fmeas_pkg::*;
#(
    parameter int NUM_OSC = DEF_NUM_OSC,
    parameter int SEL_W   = fmeas_clog2(NUM_OSC)
) (
    input  logic [NUM_OSC-1:0] mask_i,
    input  logic [SEL_W-1:0]   idx_i,
    output logic [SEL_W-1:0]   next_o,
    output logic               wrap_o
);

    always_comb begin
        next_o = idx_i;
        wrap_o = 1'b1;
        // Descending loops: the last hit is the lowest qualifying index.
        for (int i = NUM_OSC - 1; i >= 0; i--) begin
            if (mask_i[i]) next_o = SEL_W'(i);
        end
        for (int i = NUM_OSC - 1; i >= 0; i--) begin
            if (mask_i[i] && (SEL_W'(i) > idx_i)) begin
                next_o = SEL_W'(i);
                wrap_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fmeas_sequencer.sv
// Time-shares one frequency counter among NUM_OSC ring oscillators.
// state    | meaning
// S_IDLE   | waiting for start with a nonzero mask
// S_RESET  | counter held in reset, mux switches here
// S_GATE   | counter runs for the latched gate length
// S_LATCH  | latch request held high
// S_SETTLE | latched count settles, captured on last cycle
// S_OUTPUT | result presented until accepted
module fmeas_sequencer
    import fmeas_pkg::*;
#(
    parameter int NUM_OSC    = DEF_NUM_OSC,
    parameter int SEL_W      = fmeas_clog2(NUM_OSC),
    parameter int LENGTH     = DEF_LENGTH,
    parameter int GATE_W     = DEF_GATE_W,
    parameter int RESET_HOLD = DEF_RESET_HOLD,
    parameter int LATCH_HOLD = DEF_LATCH_HOLD,
    parameter int SETTLE     = DEF_SETTLE
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               continuous_i,
    input  logic [NUM_OSC-1:0] osc_mask_i,
    input  logic [GATE_W-1:0]  gate_cycles_i,
    output logic [SEL_W-1:0]   osc_select_o,
    output logic               meas_reset_o,
    output logic               meas_latch_o,
    input  logic [LENGTH-1:0]  cycle_count_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [LENGTH-1:0]  result_count_o,
    output logic [SEL_W-1:0]   result_osc_o,
    output logic               busy_o
);

    localparam int HOLD_MAX = fmeas_max(RESET_HOLD, fmeas_max(LATCH_HOLD, SETTLE));
    localparam int CNT_W    = fmeas_max(GATE_W, fmeas_clog2(HOLD_MAX));

    fmeas_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [GATE_W-1:0]  gate_q;
    logic [NUM_OSC-1:0] mask_q;
    logic [SEL_W-1:0]   sel_q;
    logic [LENGTH-1:0]  res_cnt_q;
    logic [SEL_W-1:0]   res_osc_q;

    logic [SEL_W-1:0]   next_sel;
    logic [SEL_W-1:0]   first_sel;
    logic               next_wrap;
    logic               tc;
    logic               mask_any;
    logic               handshake;
    logic               enter_reset;

    fmeas_next_sel #(
        .NUM_OSC (NUM_OSC),
        .SEL_W   (SEL_W)
    ) u_next_sel (
        .mask_i (mask_q),
        .idx_i  (sel_q),
        .next_o (next_sel),
        .wrap_o (next_wrap)
    );

    always_comb begin
        first_sel = '0;
        for (int i = NUM_OSC - 1; i >= 0; i--) begin
            if (osc_mask_i[i]) first_sel = SEL_W'(i);
        end
    end

    assign tc          = (cnt_q == '0);
    assign mask_any    = |osc_mask_i;
    assign handshake   = (state_q == S_OUTPUT) && result_ready_i;
    assign enter_reset = (state_d == S_RESET) && (state_q != S_RESET);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i && mask_any) state_d = S_RESET;
            S_RESET:  if (tc) state_d = S_GATE;
            S_GATE:   if (tc) state_d = S_LATCH;
            S_LATCH:  if (tc) state_d = S_SETTLE;
            S_SETTLE: if (tc) state_d = S_OUTPUT;
            S_OUTPUT: begin
                if (handshake) begin
                    if (!next_wrap || (continuous_i && mask_any)) state_d = S_RESET;
                    else                                          state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        meas_reset_o   = 1'b0;
        meas_latch_o   = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = (state_q != S_IDLE);
        case (state_q)
            S_RESET:  meas_reset_o   = 1'b1;
            S_LATCH:  meas_latch_o   = 1'b1;
            S_OUTPUT: result_valid_o = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            gate_q    <= '0;
            mask_q    <= '0;
            sel_q     <= '0;
            res_cnt_q <= '0;
            res_osc_q <= '0;
        end else if (enter_reset) begin
            cnt_q  <= CNT_W'(RESET_HOLD - 1);
            gate_q <= (gate_cycles_i == '0) ? GATE_W'(1) : gate_cycles_i;
            // Mid-pass advance keeps the mask; scan start and wrap re-sample it.
            if ((state_q == S_OUTPUT) && !next_wrap) begin
                sel_q <= next_sel;
            end else begin
                sel_q  <= first_sel;
                mask_q <= osc_mask_i;
            end
        end else if (tc) begin
            case (state_q)
                S_RESET:  cnt_q <= CNT_W'(gate_q) - CNT_W'(1);
                S_GATE:   cnt_q <= CNT_W'(LATCH_HOLD - 1);
                S_LATCH:  cnt_q <= CNT_W'(SETTLE - 1);
                S_SETTLE: begin
                    res_cnt_q <= cycle_count_i;
                    res_osc_q <= sel_q;
                end
                default:  ;
            endcase
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign osc_select_o   = sel_q;
    assign result_count_o = res_cnt_q;
    assign result_osc_o   = res_osc_q;

endmodule
